mips_bus_master: RTL and testbench

MIPS_BUS_MASTER -- requirements
Module: mips_bus_master

---
 rtl/mips_bus_pkg.sv | 32 +++
 rtl/mips_bus_master_if.sv | 37 +++
 rtl/mips_lane_align.sv | 52 +++++
 rtl/mips_bus_master.sv | 131 +++++++++++++
 tb/tb_mips_bus_master.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS bus master: access sizes,
// controller states and the alignment rule.
package mips_bus_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_DATA,
      WR,
      RESP
   } state_t;

   // Size code 3 is unused by the CPU; it is handled like a word.
   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [1:0] lane
   );
      logic bad;
      bad = 1'b0;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = lane[0];
         default:   bad = (lane != 2'b00);
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mips_bus_master_if.sv
// CPU request/response and memory bus signals of the bus master.
// master = the bus master itself, slave = CPU plus memory side.
interface mips_bus_master_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;

   modport master (
      input  req_valid, req_write, req_size, req_signed,
      input  req_addr, req_wdata, waitrequest, readdata,
      output req_ready, rsp_valid, rsp_err, rsp_rdata,
      output address, read, write, byteenable, writedata
   );

   modport slave (
      output req_valid, req_write, req_size, req_signed,
      output req_addr, req_wdata, waitrequest, readdata,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata,
      input  address, read, write, byteenable, writedata
   );

endinterface

// File: rtl/mips_lane_align.sv
// Byte-lane steering for stores and lane extraction plus
// zero/sign extension for loads. Purely combinational.
module mips_lane_align
   import mips_bus_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        sign_ext,
   input  logic [31:0] st_data,
   input  logic [31:0] bus_data,
   output logic [3:0]  be,
   output logic [31:0] lane_data,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   // store side: lane enables and replicated write data
   always_comb begin
      be        = 4'b1111;
      lane_data = st_data;
      case (size)
         SIZE_BYTE: begin
            be        = 4'b0001 << lane;
            lane_data = {4{st_data[7:0]}};
         end
         SIZE_HALF: begin
            be        = lane[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{st_data[15:0]}};
         end
         default: begin
            be        = 4'b1111;
            lane_data = st_data;
         end
      endcase
   end

   // load side: move the addressed lane to bit 0, then extend
   always_comb begin
      shifted = bus_data >> {lane, 3'b000};
      ld_data = bus_data;
      case (size)
         SIZE_BYTE:
            ld_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
         SIZE_HALF:
            ld_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
         default:
            ld_data = bus_data;
      endcase
   end

endmodule

// File: rtl/mips_bus_master.sv
// Single-outstanding CPU-to-bus master: latches one request,
// runs the bus read or write, returns a one-cycle response.
module mips_bus_master
   import mips_bus_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   mips_bus_master_if.master bus
);

   state_t      state;
   state_t      state_nx;

   logic        accept;
   logic        req_bad;

   logic        wr_q;
   logic        sgn_q;
   logic        err_q;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;

   logic [3:0]  be_w;
   logic [31:0] lanes_w;
   logic [31:0] ld_w;

   assign accept  = (state == IDLE) && bus.req_valid;
   assign req_bad = misaligned(bus.req_size, bus.req_addr[1:0]);

   mips_lane_align u_align (
      .size      (size_q),
      .lane      (lane_q),
      .sign_ext  (sgn_q),
      .st_data   (wdata_q),
      .bus_data  (bus.readdata),
      .be        (be_w),
      .lane_data (lanes_w),
      .ld_data   (ld_w)
   );

   // controller state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // next state and strobes; bus lanes only driven while a strobe is up
   always_comb begin
      state_nx       = state;
      bus.req_ready  = 1'b0;
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      bus.rsp_valid  = 1'b0;
      bus.rsp_err    = 1'b0;
      bus.byteenable = 4'b0000;
      bus.writedata  = 32'h0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (req_bad)            state_nx = RESP;
               else if (bus.req_write) state_nx = WR;
               else                    state_nx = RD;
            end
         end
         RD: begin
            bus.read       = 1'b1;
            bus.byteenable = be_w;
            if (!bus.waitrequest) state_nx = RD_DATA;
         end
         RD_DATA: begin
            state_nx = RESP;
         end
         WR: begin
            bus.write      = 1'b1;
            bus.byteenable = be_w;
            bus.writedata  = lanes_w;
            if (!bus.waitrequest) state_nx = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_q;
            state_nx      = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // request capture; fields stay frozen until the next acceptance
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= 1'b0;
         sgn_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= SIZE_BYTE;
         lane_q  <= 2'b00;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
      end else if (accept) begin
         wr_q    <= bus.req_write;
         sgn_q   <= bus.req_signed;
         err_q   <= req_bad;
         size_q  <= bus.req_size;
         lane_q  <= bus.req_addr[1:0];
         addr_q  <= {bus.req_addr[31:2], 2'b00};
         wdata_q <= bus.req_wdata;
      end
   end

   // response data changes only on the edge that enters RESP
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= 32'h0;
      end else if (state == RD_DATA) begin
         rdata_q <= ld_w;
      end else if (accept && req_bad) begin
         rdata_q <= 32'h0;
      end else if (state == WR && !bus.waitrequest) begin
         rdata_q <= 32'h0;
      end
   end

   assign bus.address   = addr_q;
   assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mips_bus_master.sv
// Directed bench for mips_bus_master: transaction-level model
// plus per-cycle compare and literal checks on key scenarios.
module tb_mips_bus_master;
   import mips_bus_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   mips_bus_master_if bus();

   mips_bus_master dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_run  = 0;
   int n_fail = 0;

   logic        chk_en  = 1'b0;
   logic        rst_chk = 1'b0;
   logic        e_ready = 1'b1;
   logic        e_read  = 1'b0;
   logic        e_write = 1'b0;
   logic        e_rsp   = 1'b0;
   logic        e_err   = 1'b0;
   logic [31:0] e_addr  = 32'h0;
   logic [31:0] e_wd    = 32'h0;
   logic [31:0] e_held  = 32'h0;
   logic [3:0]  e_be    = 4'h0;

   logic        lit_on      = 1'b0;
   logic        lit_wr      = 1'b0;
   int          lit_lat     = 0;
   int          lit_strobes = 0;
   logic [31:0] lit_addr    = 32'h0;
   logic [31:0] lit_wd      = 32'h0;
   logic [31:0] lit_rdata   = 32'h0;
   logic [3:0]  lit_be      = 4'h0;

   int          cyc       = 0;
   int          strobes   = 0;
   logic [31:0] seen_addr = 32'h0;
   logic [31:0] seen_wd   = 32'h0;
   logic [3:0]  seen_be   = 4'h0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---- model: what a request must produce, from the access rules
   function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
      return (sz == SIZE_HALF && a[0]) || (sz == SIZE_WORD && a[1:0] != 2'b00);
   endfunction

   function automatic int m_nbytes(input logic [1:0] sz);
      return (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      int n;
      int m;
      n = m_nbytes(sz);
      m = ((1 << n) - 1) << int'(a[1:0]);
      return 4'(m);
   endfunction

   function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] r;
      r = d;
      if (sz == SIZE_BYTE) r = {24'h0, d[7:0]} * 32'h01010101;
      if (sz == SIZE_HALF) r = {16'h0, d[15:0]} * 32'h00010001;
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg,
                                          input logic [31:0] a, input logic [31:0] rd);
      int          n;
      logic [31:0] mask;
      logic [31:0] v;
      n    = m_nbytes(sz);
      mask = (n == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * n)) - 32'h1);
      v    = (rd >> (8 * int'(a[1:0]))) & mask;
      if (sg && n < 4 && ((v >> (8 * n - 1)) & 32'h1) == 32'h1) v = v | ~mask;
      return v;
   endfunction

   // compare every cycle against the model's expectations
   always @(negedge clk) begin
      if (chk_en) begin
         if (bus.req_ready && bus.req_valid) begin
            cyc     = 0;
            strobes = 0;
         end else begin
            cyc++;
         end
         if (bus.read || bus.write) begin
            strobes++;
            seen_addr = bus.address;
            seen_be   = bus.byteenable;
            seen_wd   = bus.writedata;
         end
         chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
         chk("read", 32'(bus.read), 32'(e_read));
         chk("write", 32'(bus.write), 32'(e_write));
         chk("rd_wr_excl", 32'(bus.read & bus.write), 32'h0);
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
         chk("rsp_err", 32'(bus.rsp_err), 32'(e_rsp & e_err));
         chk("rsp_rdata", bus.rsp_rdata, e_held);
         if (e_read || e_write) begin
            chk("address", bus.address, e_addr);
            chk("byteenable", 32'(bus.byteenable), 32'(e_be));
         end
         if (e_write) chk("writedata", bus.writedata, e_wd);
         if (rst_chk) begin
            chk("rst_address", bus.address, 32'h0);
            chk("rst_byteenable", 32'(bus.byteenable), 32'h0);
            chk("rst_writedata", bus.writedata, 32'h0);
         end
         if (e_rsp && lit_on) begin
            chk("lit_latency", 32'(cyc), 32'(lit_lat));
            chk("lit_strobes", 32'(strobes), 32'(lit_strobes));
            chk("lit_rdata", bus.rsp_rdata, lit_rdata);
            if (lit_strobes > 0) begin
               chk("lit_address", seen_addr, lit_addr);
               chk("lit_be", 32'(seen_be), 32'(lit_be));
               if (lit_wr) chk("lit_wd", seen_wd, lit_wd);
            end
         end
      end
   end

   task automatic go_idle();
      e_ready = 1'b1;
      e_read  = 1'b0;
      e_write = 1'b0;
      e_rsp   = 1'b0;
      e_err   = 1'b0;
      bus.waitrequest = 1'b0;
      bus.readdata    = 32'h0;
   endtask

   // one request; called at posedge+1 of an IDLE cycle
   task automatic run(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int wt);
      logic        mis;
      logic [31:0] er;
      int          lat;
      logic        strobe;
      mis = m_mis(sz, a);
      er  = (wr || mis) ? 32'h0 : m_load(sz, sg, a, rd);
      lat = mis ? 1 : (wr ? wt + 2 : wt + 3);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      @(posedge clk);
      #1;
      rst_chk        = 1'b0;
      bus.req_write  = ~wr;
      bus.req_size   = ~sz;
      bus.req_signed = ~sg;
      bus.req_addr   = ~a;
      bus.req_wdata  = ~wd;
      for (int k = 1; k <= lat; k++) begin
         strobe  = !mis && (k <= wt + 1);
         e_ready = 1'b0;
         e_read  = strobe && !wr;
         e_write = strobe && wr;
         e_rsp   = (k == lat);
         e_err   = mis;
         e_addr  = {a[31:2], 2'b00};
         e_be    = m_be(sz, a);
         e_wd    = m_wd(sz, wd);
         if (k == lat) e_held = er;
         bus.req_valid   = (k < lat);
         bus.waitrequest = (k <= wt);
         bus.readdata    = (!wr && !mis && k == wt + 2) ? rd : (32'h5A5A5A5A ^ 32'(k));
         @(posedge clk);
         #1;
      end
      go_idle();
   endtask

   task automatic set_lit(input logic wr, input int lat, input int nst,
                          input logic [31:0] ad, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] rd);
      lit_on      = 1'b1;
      lit_wr      = wr;
      lit_lat     = lat;
      lit_strobes = nst;
      lit_addr    = ad;
      lit_be      = be;
      lit_wd      = wd;
      lit_rdata   = rd;
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_size   = SIZE_BYTE;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      go_idle();
      repeat (2) @(posedge clk);
      #1;
      reset   = 1'b0;
      chk_en  = 1'b1;
      rst_chk = 1'b1;
      @(posedge clk);
      #1;
      rst_chk = 1'b0;

      set_lit(1'b0, 3, 1, 32'h00000400, 4'b1111, 32'h0, 32'hDEADBEEF);
      run(1'b0, SIZE_WORD, 1'b0, 32'h00000400, 32'h0, 32'hDEADBEEF, 0);

      set_lit(1'b0, 3, 1, 32'hBFC00000, 4'b1000, 32'h0, 32'hFFFFFF80);
      run(1'b0, SIZE_BYTE, 1'b1, 32'hBFC00003, 32'h0, 32'h80123456, 0);

      set_lit(1'b0, 3, 1, 32'hBFC00000, 4'b1000, 32'h0, 32'h00000080);
      run(1'b0, SIZE_BYTE, 1'b0, 32'hBFC00003, 32'h0, 32'h80123456, 0);

      set_lit(1'b0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h00000000);
      run(1'b0, SIZE_WORD, 1'b0, 32'h00000402, 32'h0, 32'h11111111, 0);

      set_lit(1'b1, 5, 4, 32'h00000004, 4'b1100, 32'hABCDABCD, 32'h0);
      run(1'b1, SIZE_HALF, 1'b0, 32'h00000006, 32'h0000ABCD, 32'h0, 3);

      lit_on = 1'b0;
      run(1'b0, SIZE_HALF, 1'b1, 32'h00000022, 32'h0, 32'h80017FFF, 0);
      run(1'b1, SIZE_BYTE, 1'b0, 32'h00000101, 32'h123456A5, 32'h0, 1);
      run(1'b1, SIZE_WORD, 1'b0, 32'h00000200, 32'hCAFEF00D, 32'h0, 2);
      run(1'b0, SIZE_HALF, 1'b1, 32'h0000000F, 32'h0, 32'hFFFFFFFF, 0);
      run(1'b0, SIZE_WORD, 1'b1, 32'h00000300, 32'h0, 32'h80000001, 2);
      run(1'b1, SIZE_HALF, 1'b0, 32'h00000003, 32'h00001234, 32'h0, 0);
      run(1'b0, SIZE_HALF, 1'b0, 32'h00000000, 32'h0, 32'h1234F00F, 1);
      run(1'b0, SIZE_BYTE, 1'b1, 32'h00000001, 32'h0, 32'h00007F00, 0);

      // reset while a read is stalled
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_size   = SIZE_WORD;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h00001238;
      bus.waitrequest = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      e_ready = 1'b0;
      e_read  = 1'b1;
      e_addr  = 32'h00001238;
      e_be    = 4'b1111;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      go_idle();
      e_held  = 32'h0;
      rst_chk = 1'b1;
      set_lit(1'b0, 3, 1, 32'h00000010, 4'b1111, 32'h0, 32'h13579BDF);
      run(1'b0, SIZE_WORD, 1'b0, 32'h00000010, 32'h0, 32'h13579BDF, 0);
      lit_on = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
